// File: rtl/alu_ctrl_seq.sv
// Control sequencer for the multiply/divide datapath: radix-2 Booth multiply
// and non-restoring divide, then a two-word result drive onto the shared bus.
module alu_ctrl_seq #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] ibus,
    input  logic             q_lsb,
    input  logic             q_m1,
    input  logic             sign,
    output logic [9:0]       c,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_X,
        ST_LOAD_Y,
        ST_M_TEST,
        ST_M_SHIFT,
        ST_D_SHIFT,
        ST_D_ARITH,
        ST_D_QBIT,
        ST_D_CORR,
        ST_OUT_Q,
        ST_OUT_A,
        ST_DONE
    } state_t;

    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t        state;
    state_t        state_nxt;
    logic          op_q;
    logic [CW-1:0] cnt;
    logic          cnt_last;
    logic          div_by_zero;

    assign cnt_last    = (cnt == LAST_ITER);
    assign div_by_zero = op_q && (ibus == '0);

    // NOTE: every combinational output gets a default before the case, so no
    // path through the block leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_LOAD_X;
            ST_LOAD_X:  state_nxt = ST_LOAD_Y;
            ST_LOAD_Y: begin
                if (!op_q)            state_nxt = ST_M_TEST;
                else if (div_by_zero) state_nxt = ST_DONE;
                else                  state_nxt = ST_D_SHIFT;
            end
            ST_M_TEST:  state_nxt = ST_M_SHIFT;
            ST_M_SHIFT: state_nxt = cnt_last ? ST_OUT_Q : ST_M_TEST;
            ST_D_SHIFT: state_nxt = ST_D_ARITH;
            ST_D_ARITH: state_nxt = ST_D_QBIT;
            ST_D_QBIT:  state_nxt = cnt_last ? ST_D_CORR : ST_D_SHIFT;
            ST_D_CORR:  state_nxt = ST_OUT_Q;
            ST_OUT_Q:   state_nxt = ST_OUT_A;
            ST_OUT_A:   state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Control lines follow the current state; Booth and divide decisions look
    // at the datapath status bits in the same cycle.
    always_comb begin
        c = '0;
        case (state)
            ST_LOAD_X: begin
                c[0] = 1'b1;
                c[1] = 1'b1;
            end
            ST_LOAD_Y:  c[3] = 1'b1;
            ST_M_TEST: begin
                c[8] = ~q_lsb &  q_m1;
                c[9] =  q_lsb & ~q_m1;
            end
            ST_M_SHIFT: c[4] = 1'b1;
            ST_D_SHIFT: c[5] = 1'b1;
            ST_D_ARITH: begin
                c[8] =  sign;
                c[9] = ~sign;
            end
            ST_D_QBIT:  c[2] = 1'b1;
            ST_D_CORR:  c[8] = sign;
            ST_OUT_Q:   c[6] = 1'b1;
            ST_OUT_A:   c[7] = 1'b1;
            default:    c = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
            op_q  <= 1'b0;
            cnt   <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
            done  <= (state_nxt == ST_DONE);

            if (state == ST_IDLE && start) begin
                op_q <= op;
                err  <= 1'b0;
            end

            if (state == ST_LOAD_Y) begin
                cnt <= '0;
                if (div_by_zero) err <= 1'b1;
            end

            // The counter wraps on the final iteration so it is clean for the next run.
            if (state == ST_M_SHIFT || state == ST_D_QBIT) begin
                cnt <= cnt_last ? '0 : cnt + CW'(1);
            end
        end
    end

    a_add_sub_excl: assert property (@(posedge CLK) !(c[8] && c[9]));
    a_obus_excl:    assert property (@(posedge CLK) !(c[6] && c[7]));
    a_done_idle:    assert property (@(posedge CLK) !(done && busy));

endmodule
